// File: rtl/tick_generator_pkg.sv
// Shared timebase constants and counter sizing helper for the clock datapath.
// Latency: n/a (package only).
// Backpressure: n/a.
package clock_pkg;

  // Board defaults; the bench and smaller builds override through module parameters.
  localparam int DEF_CLK_HZ  = 12500;
  localparam int DEF_BASE_HZ = 50;

  // Bits needed for a counter that runs 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_generator_if.sv
// Control and strobe bundle between the timebase and its consumers.
// Latency: n/a (wiring only).
// Backpressure: none; strobes are fire-and-forget clock enables.
interface tick_generator_if;

  logic run;
  logic sync_clear;
  logic set_fast;
  logic tick_base;
  logic tick_set;
  logic tick_1hz;
  logic blink;

  // Consumer side: drives the controls, receives the strobes.
  modport master (
    output run,
    output sync_clear,
    output set_fast,
    input  tick_base,
    input  tick_set,
    input  tick_1hz,
    input  blink
  );

  // Timebase side.
  modport slave (
    input  run,
    input  sync_clear,
    input  set_fast,
    output tick_base,
    output tick_set,
    output tick_1hz,
    output blink
  );

endinterface

// File: rtl/tick_generator_counter.sv
// Modulo-N counter with runtime terminal override, clear and enable.
// Latency: count updates on the edge after en; wrap is combinational from the current count.
// Backpressure: none; en simply holds the count.
module mod_n_counter
  import clock_pkg::*;
#(
  parameter  int N = 2,
  localparam int W = cnt_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt_next,
  output logic         wrap
);

  logic [W-1:0] cnt;

  // >= rather than == so a terminal that drops below the live count still wraps.
  assign wrap = en && !clr && (cnt >= term);

  // Next count: clear beats wrap beats increment; otherwise hold.
  always_comb begin
    cnt_next = cnt;
    if (clr) begin
      cnt_next = '0;
    end else if (wrap) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = cnt + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/tick_generator.sv
// Timebase: base, set-repeat and 1 Hz clock-enable strobes plus a 1 Hz blink level.
// Latency: all outputs registered; first tick_base CLK_HZ/BASE_HZ cycles after reset release.
// Backpressure: run=0 freezes every phase and silences the strobes; no data is dropped.
module tick_generator
  import clock_pkg::*;
#(
  parameter int CLK_HZ      = DEF_CLK_HZ,
  parameter int BASE_HZ     = DEF_BASE_HZ,
  parameter int SET_SLOW_HZ = 5,
  parameter int SET_FAST_HZ = 10
) (
  input  logic             clk,
  input  logic             rst,
  tick_generator_if.slave  tg
);

  localparam int PRE    = CLK_HZ / BASE_HZ;
  localparam int SLOW_N = BASE_HZ / SET_SLOW_HZ;
  localparam int FAST_N = BASE_HZ / SET_FAST_HZ;
  localparam int SET_N  = (SLOW_N > FAST_N) ? SLOW_N : FAST_N;

  localparam int PRE_W = cnt_width(PRE);
  localparam int SET_W = cnt_width(SET_N);
  localparam int SEC_W = cnt_width(BASE_HZ);

  localparam logic [PRE_W-1:0] PRE_TERM  = PRE_W'(PRE - 1);
  localparam logic [SET_W-1:0] SLOW_TERM = SET_W'(SLOW_N - 1);
  localparam logic [SET_W-1:0] FAST_TERM = SET_W'(FAST_N - 1);
  localparam logic [SEC_W-1:0] SEC_TERM  = SEC_W'(BASE_HZ - 1);
  localparam logic [SEC_W-1:0] SEC_HALF  = SEC_W'(BASE_HZ / 2);

  if (CLK_HZ % BASE_HZ != 0) begin : g_chk_pre
    $error("tick_generator: CLK_HZ must be a multiple of BASE_HZ");
  end
  if (BASE_HZ % 2 != 0) begin : g_chk_even
    $error("tick_generator: BASE_HZ must be even");
  end
  if (BASE_HZ % SET_SLOW_HZ != 0) begin : g_chk_slow
    $error("tick_generator: BASE_HZ must be a multiple of SET_SLOW_HZ");
  end
  if (BASE_HZ % SET_FAST_HZ != 0) begin : g_chk_fast
    $error("tick_generator: BASE_HZ must be a multiple of SET_FAST_HZ");
  end

  logic             inc;
  logic [PRE_W-1:0] pre_next;
  logic             unused_pre_wrap;
  logic             base_nxt;
  logic [SET_W-1:0] set_term;
  logic [SET_W-1:0] unused_set_next;
  logic             set_wrap;
  logic [SEC_W-1:0] sec_next;
  logic             sec_wrap;

  // A clear request wins over run and suppresses counting in the same cycle.
  assign inc = tg.run && !tg.sync_clear;

  // tick_base lands in the cycle the prescaler sits on its last count, so the
  // strobe register is loaded as the prescaler steps into that count.
  assign base_nxt = inc && (pre_next == PRE_TERM);

  assign set_term = tg.set_fast ? FAST_TERM : SLOW_TERM;

  mod_n_counter #(.N(PRE)) u_pre (
    .clk      (clk),
    .rst      (rst),
    .en       (inc),
    .clr      (tg.sync_clear),
    .term     (PRE_TERM),
    .cnt_next (pre_next),
    .wrap     (unused_pre_wrap)
  );

  // Second-stage counters step together with each base strobe, so their wrap
  // lines up with the tick_base that completes the interval.
  mod_n_counter #(.N(SET_N)) u_set (
    .clk      (clk),
    .rst      (rst),
    .en       (base_nxt),
    .clr      (tg.sync_clear),
    .term     (set_term),
    .cnt_next (unused_set_next),
    .wrap     (set_wrap)
  );

  mod_n_counter #(.N(BASE_HZ)) u_sec (
    .clk      (clk),
    .rst      (rst),
    .en       (base_nxt),
    .clr      (tg.sync_clear),
    .term     (SEC_TERM),
    .cnt_next (sec_next),
    .wrap     (sec_wrap)
  );

  // Output strobes and blink level; blink rises at the half-second tick and falls with tick_1hz.
  always_ff @(posedge clk) begin
    if (rst) begin
      tg.tick_base <= 1'b0;
      tg.tick_set  <= 1'b0;
      tg.tick_1hz  <= 1'b0;
      tg.blink     <= 1'b0;
    end else if (tg.sync_clear) begin
      tg.tick_base <= 1'b0;
      tg.tick_set  <= 1'b0;
      tg.tick_1hz  <= 1'b0;
      tg.blink     <= 1'b0;
    end else begin
      tg.tick_base <= base_nxt;
      tg.tick_set  <= set_wrap;
      tg.tick_1hz  <= sec_wrap;
      if (sec_wrap) begin
        tg.blink <= 1'b0;
      end else if (base_nxt && (sec_next == SEC_HALF)) begin
        tg.blink <= 1'b1;
      end
    end
  end

endmodule
